// File: rtl/or_cells_pkg.sv
// or_cells_pkg: shared constants and helpers for the sticky OR-reduce cells
package or_cells_pkg;
  localparam int N_IN_MAX = 32;
  localparam int LEVEL = 0;
  localparam int RISE = 1;
  function automatic int lsb_idx(input logic [N_IN_MAX-1:0] v);
    lsb_idx = 0;
    for (int i = N_IN_MAX - 1; i >= 0; i--) if (v[i]) lsb_idx = i;
  endfunction
endpackage

// File: rtl/sticky_bit.sv
// sticky_bit: one capture flop where a new capture always wins over a clear
module sticky_bit
  import or_cells_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cap_i,
  input  logic clr_i,
  output logic sta_o,
  output logic nxt_o
);
  logic sta_q, sta_d;
  assign sta_d = cap_i | (sta_q & ~clr_i);
  always_ff @(posedge clk) sta_q <= rst ? 1'b0 : sta_d;
  assign sta_o = sta_q;
  assign nxt_o = sta_d;
endmodule

// File: rtl/sticky_or_reduce.sv
// sticky_or_reduce: sticky event capture with masked OR output and first-source index
module sticky_or_reduce
  import or_cells_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int EDGE_MODE = LEVEL
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_IN-1:0]         IN,
  input  logic [N_IN-1:0]         MASK,
  input  logic [N_IN-1:0]         CLR,
  output logic [N_IN-1:0]         STATUS,
  output logic                    Q,
  output logic [$clog2(N_IN)-1:0] FIRST,
  output logic                    FIRST_VLD
);
  localparam int FW = $clog2(N_IN);
  logic [N_IN-1:0] prev_q, cap, sta_d;
  logic q_q, vld_q, vld_d;
  logic [FW-1:0] first_q, first_d;
  assign cap = (EDGE_MODE == RISE) ? (IN & ~prev_q) : IN;
  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    sticky_bit u_bit (
      .clk  (CLK),
      .rst  (RST),
      .cap_i(cap[i]),
      .clr_i(CLR[i]),
      .sta_o(STATUS[i]),
      .nxt_o(sta_d[i])
    );
  end
  // FIRST latches only while invalid; validity drops once STATUS is about to empty
  always_comb begin
    vld_d = (sta_d == '0) ? 1'b0 : (vld_q | (|cap));
    first_d = (!vld_q && |cap) ? FW'(lsb_idx(N_IN_MAX'(cap))) : first_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      q_q <= 1'b0;
      vld_q <= 1'b0;
      first_q <= '0;
    end else begin
      prev_q <= IN;
      q_q <= |(STATUS & MASK);
      vld_q <= vld_d;
      first_q <= first_d;
    end
  end
  assign Q = q_q;
  assign FIRST = first_q;
  assign FIRST_VLD = vld_q;
endmodule

// File: tb/tb_sticky_or_reduce.sv
// tb_sticky_or_reduce: scoreboard bench for level and rising-edge variants
module tb_sticky_or_reduce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_l = '0, mask_l = 4'hF, clr_l = '0, st_l;
  logic [3:0] in_e = '0, mask_e = 4'hF, clr_e = '0, st_e;
  logic q_l, fv_l, q_e, fv_e;
  logic [1:0] f_l, f_e;
  typedef struct packed {logic [3:0] st; logic q; logic [1:0] f; logic fv; logic [3:0] prev;} ms_t;
  typedef struct packed {logic [3:0] st; logic q; logic [1:0] f; logic fv;} obs_t;
  ms_t ml = '0, me = '0;
  obs_t ql[$], qe[$];
  obs_t el, ee;
  int checks = 0, errors = 0;

  sticky_or_reduce #(.N_IN(4), .EDGE_MODE(0)) u_lvl (
    .CLK(clk), .RST(rst), .IN(in_l), .MASK(mask_l), .CLR(clr_l),
    .STATUS(st_l), .Q(q_l), .FIRST(f_l), .FIRST_VLD(fv_l)
  );
  sticky_or_reduce #(.N_IN(4), .EDGE_MODE(1)) u_edg (
    .CLK(clk), .RST(rst), .IN(in_e), .MASK(mask_e), .CLR(clr_e),
    .STATUS(st_e), .Q(q_e), .FIRST(f_e), .FIRST_VLD(fv_e)
  );

  always #5 clk = ~clk;

  function automatic ms_t mnext(ms_t s, logic [3:0] in, logic [3:0] mask, logic [3:0] clr, bit em, logic r);
    ms_t n;
    logic [3:0] cap;
    n = '0;
    if (r) return n;
    cap = em ? (in & ~s.prev) : in;
    n.st = cap | (s.st & ~clr);
    n.q = |(s.st & mask);
    n.prev = in;
    n.f = s.f;
    n.fv = s.fv;
    if (n.st == 4'b0) n.fv = 1'b0;
    else if (!s.fv && cap != 4'b0) begin
      n.fv = 1'b1;
      for (int i = 3; i >= 0; i--) if (cap[i]) n.f = 2'(i);
    end
    return n;
  endfunction

  task automatic tick();
    ml = mnext(ml, in_l, mask_l, clr_l, 1'b0, rst);
    me = mnext(me, in_e, mask_e, clr_e, 1'b1, rst);
    ql.push_back({ml.st, ml.q, ml.f, ml.fv});
    qe.push_back({me.st, me.q, me.f, me.fv});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_l = 4'hF;
    in_e = 4'hF;
    for (int k = 0; k < 2; k++) begin
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if ({st_l, q_l, f_l, fv_l} !== 8'h0 || {st_e, q_e, f_e, fv_e} !== 8'h0 || el != 8'h0 || ee != 8'h0) begin
        errors++;
        $display("FAIL reset: lvl=%h edg=%h need 00", {st_l, q_l, f_l, fv_l}, {st_e, q_e, f_e, fv_e});
      end
    end
    in_l = '0;
    in_e = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      in_l = (k == 0) ? 4'b0100 : 4'b0;
      clr_l = (k == 2) ? 4'b0100 : 4'b0;
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL basic_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      if (k == 0) begin
        checks++;
        if (st_l !== 4'b0100 || q_l !== 1'b0 || f_l !== 2'd2 || fv_l !== 1'b1) begin
          errors++;
          $display("FAIL basic_edge1: got st=%b q=%b f=%0d v=%b need 0100/0/2/1", st_l, q_l, f_l, fv_l);
        end
      end
      if (k == 1) begin
        checks++;
        if (q_l !== 1'b1 || st_l !== 4'b0100) begin
          errors++;
          $display("FAIL basic_edge2: got q=%b st=%b need 1/0100", q_l, st_l);
        end
      end
    end
    clr_l = '0;
  endtask

  task automatic test_set_over_clear();
    for (int k = 0; k < 5; k++) begin
      in_l = (k == 0 || k == 2) ? 4'b0010 : 4'b0;
      clr_l = (k == 2 || k == 3) ? 4'b0010 : 4'b0;
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL set_over_clear_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      if (k == 2) begin
        checks++;
        if (st_l[1] !== 1'b1 || q_l !== 1'b1) begin
          errors++;
          $display("FAIL set_wins: got st1=%b q=%b need 1/1", st_l[1], q_l);
        end
      end
    end
    clr_l = '0;
  endtask

  task automatic test_first();
    for (int k = 0; k < 4; k++) begin
      in_l = (k == 0) ? 4'b1001 : 4'b0;
      clr_l = (k == 1) ? 4'b0001 : (k == 2) ? 4'b1000 : 4'b0;
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL first_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      if (k < 2) begin
        checks++;
        if (f_l !== 2'd0 || fv_l !== 1'b1) begin
          errors++;
          $display("FAIL first_hold_%0d: got f=%0d v=%b need 0/1", k, f_l, fv_l);
        end
      end
      if (k == 2) begin
        checks++;
        if (fv_l !== 1'b0 || st_l !== 4'b0) begin
          errors++;
          $display("FAIL first_drop: got v=%b st=%b need 0/0000", fv_l, st_l);
        end
      end
      if (k == 3) begin
        checks++;
        if (q_l !== 1'b0) begin
          errors++;
          $display("FAIL first_q_low: got q=%b need 0", q_l);
        end
      end
    end
    clr_l = '0;
  endtask

  task automatic test_edge();
    for (int c = 1; c <= 15; c++) begin
      in_e = (c <= 10 || c == 12 || c == 13) ? 4'b1000 : 4'b0;
      clr_e = (c == 5 || c == 14) ? 4'b1000 : 4'b0;
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_e !== ee.st || q_e !== ee.q || fv_e !== ee.fv || (ee.fv && f_e !== ee.f)) begin
        errors++;
        $display("FAIL edge_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", c, st_e, q_e, f_e, fv_e, ee.st, ee.q, ee.f, ee.fv);
      end
      if (c == 1 || (c >= 5 && c <= 10) || c == 12) begin
        checks++;
        if (st_e[3] !== (c == 1 || c == 12)) begin
          errors++;
          $display("FAIL edge_capture_%0d: got st3=%b need %b", c, st_e[3], (c == 1 || c == 12));
        end
      end
    end
    clr_e = '0;
  endtask

  task automatic test_mask();
    for (int k = 0; k < 6; k++) begin
      in_l = (k == 0) ? 4'b0110 : 4'b0;
      mask_l = (k < 3) ? 4'b0 : (k == 3) ? 4'b0010 : 4'hF;
      clr_l = (k == 4) ? 4'b0110 : 4'b0;
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL mask_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (q_l !== (k == 3) || st_l !== 4'b0110) begin
          errors++;
          $display("FAIL mask_q_%0d: got q=%b st=%b need %b/0110", k, q_l, st_l, (k == 3));
        end
      end
    end
    clr_l = '0;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) begin
      in_l = (k == 0) ? 4'hF : (k == 2) ? 4'b0100 : 4'b0;
      rst = (k == 2);
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL mid_reset_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      if (k >= 2) begin
        checks++;
        if ({st_l, q_l, f_l, fv_l} !== 8'h0) begin
          errors++;
          $display("FAIL mid_reset_clear_%0d: got st=%b q=%b f=%0d v=%b need all 0", k, st_l, q_l, f_l, fv_l);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_l = 4'($urandom);
      mask_l = 4'($urandom);
      clr_l = 4'($urandom & $urandom);
      in_e = 4'($urandom);
      mask_e = 4'($urandom);
      clr_e = 4'($urandom & $urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
      el = ql.pop_front();
      ee = qe.pop_front();
      checks++;
      if (st_l !== el.st || q_l !== el.q || fv_l !== el.fv || (el.fv && f_l !== el.f)) begin
        errors++;
        $display("FAIL random_lvl_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_l, q_l, f_l, fv_l, el.st, el.q, el.f, el.fv);
      end
      checks++;
      if (st_e !== ee.st || q_e !== ee.q || fv_e !== ee.fv || (ee.fv && f_e !== ee.f)) begin
        errors++;
        $display("FAIL random_edg_%0d: got st=%b q=%b f=%0d v=%b exp st=%b q=%b f=%0d v=%b", k, st_e, q_e, f_e, fv_e, ee.st, ee.q, ee.f, ee.fv);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_set_over_clear();
    test_first();
    test_edge();
    test_mask();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
